// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and sizing for the fetch-side instruction FIFO.
// Holds the default payload type, the default depth and the occupancy
// counter type, plus a helper that derives counter width from a depth.
package fetch_pkg;

    // Default fetched-packet payload
    typedef logic [31:0] fetch_pkt_t;

    // Default number of FIFO entries (power of two, at least 2)
    localparam int FETCH_FIFO_DEPTH = 8;

    // Pointer width and occupancy width for the default depth
    localparam int FETCH_PTR_W = $clog2(FETCH_FIFO_DEPTH);
    localparam int FETCH_CNT_W = FETCH_PTR_W + 1;

    // Occupancy counter for the default depth: must represent 0..DEPTH inclusive
    typedef logic [FETCH_CNT_W-1:0] fetch_cnt_t;

    // Occupancy width for an arbitrary depth (one extra bit so "full" fits)
    function automatic int fetch_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x T storage array for the fetch FIFO.
// One synchronous write port, one asynchronous (combinational) read port.
// The array carries no reset: occupancy is tracked by the controller, so
// stale contents are never presented as valid.
module fifo_mem
    import fetch_pkg::*;
#(
    parameter type T     = fetch_pkt_t,
    parameter int  DEPTH = FETCH_FIFO_DEPTH,
    parameter int  AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  T              wdata,
    input  logic [AW-1:0] raddr,
    output T              rdata
);

    T mem_q [DEPTH];

    // Write the incoming packet into the addressed slot on an enabled edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port is purely combinational so the oldest entry is visible
    // in the same cycle the read pointer points at it
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular FIFO between instruction fetch and the decode skid
// buffer. Valid/ready on both sides, occupancy output for fetch throttling,
// single-cycle flush for branch redirect, asynchronous active-high reset.
//
// Optional feature: define FETCH_FIFO_BYPASS_EN to let a packet arriving at
// an empty FIFO appear on the output in the same cycle (combinational
// data_in -> data_out path). Without it the minimum latency is one cycle and
// no output depends combinationally on valid_in or ready_out.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type T     = fetch_pkt_t,
    parameter int  DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   valid_in,
    input  T                       data_in,
    output logic                   ready_in,
    output logic                   valid_out,
    output T                       data_out,
    input  logic                   ready_out,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fetch_cnt_width(DEPTH);

    // Occupancy value that means "every slot in use"
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    // Pointer and occupancy state
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // Handshake and storage-control signals
    logic stored_s;    // FIFO holds at least one entry and is not flushing
    logic bypass_s;    // empty-FIFO pass-through is presenting data_in
    logic push_s;      // upstream handshake completes
    logic pop_s;       // downstream handshake completes
    logic mem_we_s;    // packet actually lands in storage
    logic mem_pop_s;   // oldest stored entry actually leaves
    T     mem_rdata_s;

    fifo_mem #(
        .T     (T),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata_s)
    );

    // Derive handshake outputs and storage controls from state, flush and reset
    always_comb begin
        stored_s = !flush && (count_q != '0);

`ifdef FETCH_FIFO_BYPASS_EN
        // Empty and not being cleared: hand data_in straight to the output
        bypass_s = !reset && !flush && (count_q == '0) && valid_in;
`else
        bypass_s = 1'b0;
`endif

        // A full FIFO refuses a push even if it pops in the same cycle;
        // this keeps ready_in independent of ready_out
        ready_in  = !reset && !flush && (count_q != FULL_C);
        valid_out = stored_s || bypass_s;

        if (stored_s) begin
            data_out = mem_rdata_s;
        end else if (bypass_s) begin
            data_out = data_in;
        end else begin
            data_out = '0;
        end

        push_s = valid_in && ready_in;
        pop_s  = valid_out && ready_out;

        // A bypassed packet taken immediately by the consumer never touches
        // storage; if the consumer stalls it is written like any other push
        mem_we_s  = push_s && !(bypass_s && ready_out);
        mem_pop_s = pop_s && stored_s;
    end

    // Next pointer/occupancy values; flush wins over any handshake
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap modulo DEPTH by natural overflow
            if (mem_we_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (mem_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            case ({mem_we_s, mem_pop_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset drops all entries immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_fifo.sv
// tb_fetch_fifo: directed and randomized checks of fetch_fifo (DEPTH=4,
// 16-bit payload) against a queue-based reference model. Also exercises the
// same-cycle pass-through when FETCH_FIFO_BYPASS_EN is defined.
module tb_fetch_fifo;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        valid_in;
    logic [15:0] data_in;
    logic        ready_in;
    logic        valid_out;
    logic [15:0] data_out;
    logic        ready_out;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    // Reference model: the queue holds exactly the packets the FIFO owns,
    // oldest first
    logic [15:0] q[$];
    bit          last_push = 1'b0;
    bit          bypass_mode = 1'b0;

    fetch_fifo #(
        .T     (logic [15:0]),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_out (ready_out),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready_in();
        return !reset && !flush && (q.size() != DEPTH);
    endfunction

    function automatic bit exp_bypass();
        return bypass_mode && !reset && !flush && (q.size() == 0) && valid_in;
    endfunction

    function automatic bit exp_valid_out();
        return (!flush && q.size() != 0) || exp_bypass();
    endfunction

    function automatic logic [15:0] exp_data_out();
        if (!flush && q.size() != 0) return q[0];
        else if (exp_bypass()) return data_in;
        else return 16'h0000;
    endfunction

    task automatic check_outputs();
        check("ready_in",  32'(ready_in),  32'(exp_ready_in()));
        check("valid_out", 32'(valid_out), 32'(exp_valid_out()));
        check("data_out",  32'(data_out),  32'(exp_data_out()));
        check("count",     32'(count),     32'(q.size()));
    endtask

    // Apply one clock edge to the model: push lands at the back, pop takes
    // the front (a bypassed packet is pushed and popped in the same step)
    task automatic model_update();
        bit          do_push;
        bit          do_pop;
        logic [15:0] tmp;
        do_push   = valid_in && exp_ready_in();
        do_pop    = exp_valid_out() && ready_out;
        last_push = do_push;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (do_push) q.push_back(data_in);
            if (do_pop) tmp = q.pop_front();
        end
    endtask

    // One cycle: check outputs mid-cycle, then advance model with the edge
    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic offer(input logic [15:0] val);
        valid_in = 1'b1;
        data_in  = val;
        last_push = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_push) break;
        end
        if (!last_push) begin
            checks++;
            errors++;
            $error("FAIL offer_timeout: observed not accepted, expected accepted for %0h", val);
        end
    endtask

    task automatic drain();
        valid_in  = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
`ifdef FETCH_FIFO_BYPASS_EN
        bypass_mode = 1'b1;
`endif
        reset     = 1'b1;
        flush     = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        data_in   = 16'h0000;

        // Reset state
        #1;
        check("rst_ready_in",  32'(ready_in),  32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_data_out",  32'(data_out),  32'd0);
        check("rst_count",     32'(count),     32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rel_ready_in", 32'(ready_in), 32'd1);

        // Pass-through with consumer always ready
        ready_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            data_in  = 16'(i);
            tick();
            check("pt_valid_out", 32'(valid_out), 32'd1);
            check("pt_data_out",  32'(data_out),  32'(i));
            check("pt_count_le1", 32'(count <= 3'd1), 32'd1);
        end
        valid_in = 1'b0;
        tick();
        tick();

        // Fill to full, hold a fifth offer, pop one, accept the held packet
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) offer(16'h0100 + 16'(i));
        valid_in = 1'b0;
        check("full_count",    32'(count),    32'd4);
        check("full_ready_in", 32'(ready_in), 32'd0);
        valid_in = 1'b1;
        data_in  = 16'h0104;
        tick();
        check("held_count", 32'(count), 32'd4);
        ready_out = 1'b1;
        tick();
        ready_out = 1'b0;
        check("after_pop_ready_in", 32'(ready_in), 32'd1);
        check("after_pop_count",    32'(count),    32'd3);
        tick();
        check("refill_count", 32'(count), 32'd4);
        valid_in  = 1'b0;
        ready_out = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("fill_order", 32'(data_out), 32'(16'h0101 + 16'(k)));
            tick();
        end
        check("fill_empty", 32'(count), 32'd0);

        // Simultaneous push/pop at count 2 across pointer wrap
        ready_out = 1'b0;
        offer(16'h0200);
        offer(16'h0201);
        ready_out = 1'b1;
        for (int i = 0; i < 12; i++) begin
            valid_in = 1'b1;
            data_in  = 16'h0202 + 16'(i);
            tick();
            check("steady_count", 32'(count), 32'd2);
        end
        drain();

        // Flush at count 3 with a packet being offered
        ready_out = 1'b0;
        offer(16'h02F0);
        offer(16'h02F1);
        offer(16'h02F2);
        valid_in = 1'b1;
        data_in  = 16'h02FF;
        flush    = 1'b1;
        #1;
        check("flush_ready_in",  32'(ready_in),  32'd0);
        check("flush_valid_out", 32'(valid_out), 32'd0);
        tick();
        flush    = 1'b0;
        valid_in = 1'b0;
        #1;
        check("post_flush_count", 32'(count),     32'd0);
        check("post_flush_valid", 32'(valid_out), 32'd0);
        ready_out = 1'b1;
        offer(16'h0300);
        check("post_flush_data",  32'(data_out),  32'h0300);
        check("post_flush_vout",  32'(valid_out), 32'd1);
        valid_in = 1'b0;
        tick();
        tick();

        // Asynchronous reset in the middle of a cycle at count 2
        ready_out = 1'b0;
        offer(16'h0400);
        offer(16'h0401);
        valid_in = 1'b0;
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        check("arst_count",     32'(count),     32'd0);
        check("arst_valid_out", 32'(valid_out), 32'd0);
        check("arst_data_out",  32'(data_out),  32'd0);
        check("arst_ready_in",  32'(ready_in),  32'd0);
        tick();
        check("arst_hold_ready_in", 32'(ready_in), 32'd0);
        reset = 1'b0;
        #1;
        check("arst_rel_ready_in", 32'(ready_in), 32'd1);
        tick();

        // Random stress: 70% valid_in, 50% ready_out, upstream holds while stalled
        valid_in  = 1'b0;
        last_push = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!valid_in || last_push) begin
                valid_in = ($urandom_range(0, 99) < 70);
                data_in  = 16'($urandom);
            end
            ready_out = ($urandom_range(0, 99) < 50);
            tick();
        end
        drain();

`ifdef FETCH_FIFO_BYPASS_EN
        // Same-cycle pass-through when empty and the consumer is ready
        valid_in  = 1'b1;
        data_in   = 16'h0ABC;
        ready_out = 1'b1;
        #1;
        check("byp_valid_out", 32'(valid_out), 32'd1);
        check("byp_data_out",  32'(data_out),  32'h0ABC);
        tick();
        check("byp_count", 32'(count), 32'd0);
        valid_in = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
